// File: rtl/floor_call_if.sv
// Call-button front-end bus: controller-side inputs and conditioned call outputs.
interface floor_call_if;
  logic       ena;
  logic [3:0] btn_raw;
  logic [1:0] cur_floor;
  logic       floor_valid;
  logic [3:0] pending;
  logic [3:0] call;
  logic       any_call;

  modport master (
    output ena, btn_raw, cur_floor, floor_valid,
    input  pending, call, any_call
  );

  modport slave (
    input  ena, btn_raw, cur_floor, floor_valid,
    output pending, call, any_call
  );
endinterface

// File: rtl/floor_call_conditioner.sv
// Four-stop call conditioner: synchronise and debounce the call buttons, latch
// presses as pending calls until the car arrives, and present the nearest one.
module floor_call_conditioner #(
  parameter  int DB_CYCLES = 16,
  localparam int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic         clk,
  input  logic         rst_n,
  floor_call_if.slave  bus
);

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_db;
  logic [3:0]       r_db_d;
  logic [CNT_W-1:0] r_cnt [4];
  logic [3:0]       r_pending;
  logic [3:0]       r_call;
  logic             r_any_call;

  logic [3:0]       w_rise;
  logic [3:0]       w_clear;
  logic [3:0]       w_sel;
  logic [2:0]       w_best;
  logic [2:0]       w_dist;

  assign w_rise = r_db & ~r_db_d;

  // Arrival at a settled floor cancels that floor's call.
  always_comb begin
    w_clear = '0;
    for (int i = 0; i < 4; i++) begin
      w_clear[i] = bus.floor_valid && (bus.cur_floor == 2'(i));
    end
  end

  // Nearest pending floor; the strict compare keeps the lower floor on a tie.
  always_comb begin
    w_sel  = '0;
    w_best = 3'd7;
    w_dist = '0;
    for (int j = 0; j < 4; j++) begin
      if (3'(j) >= {1'b0, bus.cur_floor}) begin
        w_dist = 3'(j) - {1'b0, bus.cur_floor};
      end else begin
        w_dist = {1'b0, bus.cur_floor} - 3'(j);
      end
      if (r_pending[j] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_sel  = 4'(1) << j;
      end
    end
  end

  // Per-button synchroniser, debounce counter and edge-detect delay.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (bus.ena) begin
      r_sync1 <= bus.btn_raw;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Pending calls (clear beats set) and the registered call selection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_call     <= '0;
      r_any_call <= 1'b0;
    end else if (bus.ena) begin
      r_pending  <= (r_pending | w_rise) & ~w_clear;
      r_call     <= w_sel;
      r_any_call <= (r_pending != 4'd0);
    end
  end

  assign bus.pending  = r_pending;
  assign bus.call     = r_call;
  assign bus.any_call = r_any_call;

endmodule

// File: tb/tb_floor_call_conditioner.sv
// Bench for floor_call_conditioner: directed vector table followed by random
// stimulus checked against a behavioural model.
module tb_floor_call_conditioner;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n;

  floor_call_if u_if ();

  floor_call_conditioner #(.DB_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       r;
    logic       e;
    logic [3:0] b;
    logic [1:0] c;
    logic       f;
    int         hold;
    logic [3:0] ep;
    logic [3:0] ec;
    logic       ea;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state
  int         m_s1[4], m_s2[4], m_db[4], m_dbd[4], m_run[4];
  logic [3:0] m_pend, m_call;
  logic       m_any;

  task automatic model_step();
    logic [3:0] np;
    int lo, hi;
    bit found;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_dbd[i] = 0; m_run[i] = 0;
      end
      m_pend = '0; m_call = '0; m_any = 1'b0;
    end else if (u_if.ena) begin
      np = m_pend;
      for (int i = 0; i < 4; i++) begin
        if (u_if.floor_valid && int'(u_if.cur_floor) == i) np[i] = 1'b0;
        else if (m_db[i] == 1 && m_dbd[i] == 0) np[i] = 1'b1;
      end
      // Search outward from the car, lower side first at each distance.
      m_any  = (m_pend != 4'd0);
      m_call = '0;
      found  = 1'b0;
      for (int d = 0; d < 4; d++) begin
        lo = int'(u_if.cur_floor) - d;
        hi = int'(u_if.cur_floor) + d;
        if (!found && lo >= 0) begin
          if (m_pend[lo]) begin m_call[lo] = 1'b1; found = 1'b1; end
        end
        if (!found && hi <= 3) begin
          if (m_pend[hi]) begin m_call[hi] = 1'b1; found = 1'b1; end
        end
      end
      // Level must disagree for D consecutive enabled cycles to be accepted.
      for (int i = 0; i < 4; i++) begin
        m_dbd[i] = m_db[i];
        if (m_s2[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_db[i]  = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = int'(u_if.btn_raw[i]);
      end
      m_pend = np;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] b,
                      input logic [1:0] c, input logic f);
    @(negedge clk);
    rst_n           = r;
    u_if.ena        = e;
    u_if.btn_raw    = b;
    u_if.cur_floor  = c;
    u_if.floor_valid = f;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] ep,
                       input logic [3:0] ec, input logic ea);
    n_vec++;
    if (u_if.pending !== ep || u_if.call !== ec || u_if.any_call !== ea) begin
      n_bad++;
      $display("FAIL %s: got pending=%b call=%b any_call=%b, expected pending=%b call=%b any_call=%b",
               name, u_if.pending, u_if.call, u_if.any_call, ep, ec, ea);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [3:0] b,
                     input logic [1:0] c, input logic f, input int hold,
                     input logic [3:0] ep, input logic [3:0] ec, input logic ea);
    vec_t v;
    v.r = r; v.e = e; v.b = b; v.c = c; v.f = f; v.hold = hold;
    v.ep = ep; v.ec = ec; v.ea = ea;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0] rb;
    logic [1:0] rc;
    rst_n = 1'b0;
    u_if.ena = 1'b1; u_if.btn_raw = '0; u_if.cur_floor = '0; u_if.floor_valid = 1'b0;

    //   r     e     btn      cur   fv   hold  pending  call     any
    add(1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 2,  4'b0000, 4'b0000, 1'b0); // reset
    add(1'b1, 1'b1, 4'b0100, 2'd0, 1'b0, 6,  4'b0000, 4'b0000, 1'b0); // debouncing
    add(1'b1, 1'b1, 4'b0100, 2'd0, 1'b0, 1,  4'b0100, 4'b0000, 1'b0); // latched at D+3
    add(1'b1, 1'b1, 4'b0100, 2'd0, 1'b0, 1,  4'b0100, 4'b0100, 1'b1); // call at D+4
    add(1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 10, 4'b0100, 4'b0100, 1'b1); // release holds
    add(1'b1, 1'b1, 4'b1000, 2'd0, 1'b0, 3,  4'b0100, 4'b0100, 1'b1); // short pulse
    add(1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 10, 4'b0100, 4'b0100, 1'b1); // pulse rejected
    add(1'b1, 1'b1, 4'b0001, 2'd1, 1'b0, 8,  4'b0101, 4'b0001, 1'b1); // tie -> lower
    add(1'b1, 1'b1, 4'b0000, 2'd1, 1'b0, 8,  4'b0101, 4'b0001, 1'b1);
    add(1'b1, 1'b1, 4'b0000, 2'd2, 1'b1, 1,  4'b0001, 4'b0100, 1'b1); // clear L2
    add(1'b1, 1'b1, 4'b0000, 2'd2, 1'b0, 1,  4'b0001, 4'b0001, 1'b1);
    add(1'b1, 1'b1, 4'b1000, 2'd2, 1'b0, 8,  4'b1001, 4'b1000, 1'b1); // nearest L3
    add(1'b1, 1'b1, 4'b0000, 2'd2, 1'b0, 8,  4'b1001, 4'b1000, 1'b1);
    add(1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 8,  4'b1001, 4'b1000, 1'b1); // clear beats rise
    add(1'b1, 1'b1, 4'b0000, 2'd2, 1'b0, 8,  4'b1001, 4'b1000, 1'b1);
    add(1'b1, 1'b1, 4'b0000, 2'd3, 1'b1, 1,  4'b0001, 4'b1000, 1'b1);
    add(1'b1, 1'b1, 4'b0000, 2'd3, 1'b0, 1,  4'b0001, 4'b0001, 1'b1);
    add(1'b1, 1'b1, 4'b0000, 2'd0, 1'b1, 1,  4'b0000, 4'b0001, 1'b1);
    add(1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1,  4'b0000, 4'b0000, 1'b0); // call drops
    add(1'b1, 1'b1, 4'b1010, 2'd0, 1'b0, 4,  4'b0000, 4'b0000, 1'b0); // mid-debounce
    add(1'b0, 1'b1, 4'b1010, 2'd0, 1'b0, 1,  4'b0000, 4'b0000, 1'b0); // reset pulse
    add(1'b1, 1'b1, 4'b1010, 2'd0, 1'b0, 6,  4'b0000, 4'b0000, 1'b0); // fresh count
    add(1'b1, 1'b1, 4'b1010, 2'd0, 1'b0, 1,  4'b1010, 4'b0000, 1'b0);
    add(1'b1, 1'b1, 4'b1010, 2'd0, 1'b0, 1,  4'b1010, 4'b0010, 1'b1);
    add(1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 8,  4'b1010, 4'b0010, 1'b1);
    add(1'b1, 1'b1, 4'b0000, 2'd1, 1'b1, 1,  4'b1000, 4'b0010, 1'b1);
    add(1'b1, 1'b1, 4'b0000, 2'd3, 1'b1, 1,  4'b0000, 4'b1000, 1'b1);
    add(1'b1, 1'b1, 4'b0000, 2'd3, 1'b0, 1,  4'b0000, 4'b0000, 1'b0);
    add(1'b1, 1'b0, 4'b1111, 2'd3, 1'b0, 20, 4'b0000, 4'b0000, 1'b0); // frozen
    add(1'b1, 1'b1, 4'b1111, 2'd3, 1'b0, 6,  4'b0000, 4'b0000, 1'b0);
    add(1'b1, 1'b1, 4'b1111, 2'd3, 1'b0, 1,  4'b1111, 4'b0000, 1'b0);
    add(1'b1, 1'b1, 4'b1111, 2'd3, 1'b0, 1,  4'b1111, 4'b1000, 1'b1);

    for (int k = 0; k < tbl.size(); k++) begin
      for (int h = 0; h < tbl[k].hold; h++) begin
        step(tbl[k].r, tbl[k].e, tbl[k].b, tbl[k].c, tbl[k].f);
      end
      check($sformatf("vec%0d", k), tbl[k].ep, tbl[k].ec, tbl[k].ea);
    end

    // Random phase: realign model and DUT with a reset, then compare every cycle.
    step(1'b0, 1'b1, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 1'b1, 4'b0000, 2'd0, 1'b0);
    rb = '0;
    rc = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) == 0) rb[i] = ~rb[i];
      end
      if ($urandom_range(0, 11) == 0) rc = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 499) != 0), ($urandom_range(0, 9) != 0), rb, rc,
           ($urandom_range(0, 3) == 0));
      check($sformatf("rand%0d", n), m_pend, m_call, m_any);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
